// File: rtl/time_sync_scheduler_pkg.sv
// Shared types and helpers for the network time-sync scheduler.
package time_sync_pkg;

  // Scheduler sequencing states
  typedef enum logic [3:0] {
    ST_START,
    ST_REQ,
    ST_WAIT,
    ST_CHECK,
    ST_LOAD,
    ST_RETRY,
    ST_BACKOFF,
    ST_HOLD,
    ST_FAIL
  } state_t;

  // Earliest accepted network time: 2024-01-01 00:00:00 UTC
  localparam logic [31:0] MIN_VALID_TIME_DEFAULT = 32'd1704067200;

  // Bits needed for a counter running 0..n-1 (never less than one)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/time_sync_scheduler_sec_tick_gen.sv
// One-second tick generator: counts 0..CLK_HZ-1 and flags the last count.
module sec_tick_gen
  import time_sync_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = cnt_width(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == LAST);

  // Prescaler with synchronous restart from the scheduler
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/time_sync_scheduler.sv
// Sequences the network time-set engine (start, timeout, range check,
// retry with backoff, periodic resync) and owns the counter load port,
// arbitrating network results against manual set requests.
// Every interval is measured from the cycle that starts the step it
// times: response timeout from the request cycle, backoff and fail hold
// from the retry cycle, resync hold from the load cycle.
module time_sync_scheduler
  import time_sync_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100000000,
  parameter int unsigned RESP_TIMEOUT_S = 2,
  parameter int unsigned BACKOFF_S      = 1,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned RESYNC_S       = 3600,
  parameter logic [31:0] MIN_VALID_TIME = MIN_VALID_TIME_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        manual_req,
  input  logic [63:0] manual_value,
  input  logic        sync_now,
  output logic        net_en,
  input  logic        net_finished,
  input  logic [31:0] net_time,
  output logic        load_n,
  output logic [63:0] set_value,
  output logic        synced,
  output logic        fail,
  output logic [2:0]  retry_cnt
);

  localparam int unsigned SEC_MAX_A = (RESP_TIMEOUT_S > BACKOFF_S) ? RESP_TIMEOUT_S : BACKOFF_S;
  localparam int unsigned SEC_MAX   = (SEC_MAX_A > RESYNC_S) ? SEC_MAX_A : RESYNC_S;
  localparam int unsigned SEC_W     = cnt_width(SEC_MAX + 1);
  localparam logic [2:0]  RETRY_MAX = 3'(MAX_RETRY);

  state_t            state;
  logic [31:0]       captured;
  logic [SEC_W-1:0]  sec_cnt;
  logic [SEC_W-1:0]  limit_c;
  logic              tick_c;
  logic              timeout_c;
  logic              restart_c;
  logic [2:0]        retry_inc_c;

  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (restart_c),
    .tick_c (tick_c)
  );

  // Last-second index for the interval owned by the current state
  always_comb begin
    limit_c = '0;
    case (state)
      ST_WAIT:          limit_c = SEC_W'(RESP_TIMEOUT_S - 1);
      ST_RETRY,
      ST_BACKOFF:       limit_c = SEC_W'(BACKOFF_S - 1);
      ST_LOAD,
      ST_HOLD,
      ST_FAIL:          limit_c = SEC_W'(RESYNC_S - 1);
      default:          limit_c = '0;
    endcase
  end

  assign timeout_c = tick_c && (sec_cnt == limit_c);

  // Restart the timebase on any transition into REQ, RETRY or LOAD
  always_comb begin
    restart_c = 1'b0;
    case (state)
      ST_START:         restart_c = 1'b1;
      ST_WAIT:          restart_c = !net_finished && timeout_c;
      ST_CHECK:         restart_c = 1'b1;
      ST_BACKOFF:       restart_c = timeout_c;
      ST_HOLD,
      ST_FAIL:          restart_c = sync_now || timeout_c;
      default:          restart_c = 1'b0;
    endcase
  end

  // Saturating next retry count
  always_comb begin
    retry_inc_c = (retry_cnt >= RETRY_MAX) ? RETRY_MAX : retry_cnt + 3'd1;
  end

  // Seconds elapsed since the last timebase restart
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sec_cnt <= '0;
    end else if (restart_c) begin
      sec_cnt <= '0;
    end else if (tick_c) begin
      sec_cnt <= sec_cnt + SEC_W'(1);
    end
  end

  // Sequencer with registered outputs; manual set overrides any network load
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_START;
      net_en    <= 1'b0;
      load_n    <= 1'b1;
      set_value <= '0;
      synced    <= 1'b0;
      fail      <= 1'b0;
      retry_cnt <= '0;
      captured  <= '0;
    end else begin
      net_en <= 1'b0;
      load_n <= 1'b1;
      case (state)
        ST_START: state <= ST_REQ;
        ST_REQ: begin
          net_en <= 1'b1;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (net_finished) begin
            captured <= net_time;
            state    <= ST_CHECK;
          end else if (timeout_c) begin
            state <= ST_RETRY;
          end
        end
        ST_CHECK: state <= (captured >= MIN_VALID_TIME) ? ST_LOAD : ST_RETRY;
        ST_LOAD: begin
          load_n    <= 1'b0;
          set_value <= {32'd0, captured};
          synced    <= 1'b1;
          fail      <= 1'b0;
          retry_cnt <= '0;
          state     <= ST_HOLD;
        end
        ST_RETRY: begin
          retry_cnt <= retry_inc_c;
          if (retry_inc_c == RETRY_MAX) begin
            fail  <= 1'b1;
            state <= ST_FAIL;
          end else begin
            state <= ST_BACKOFF;
          end
        end
        ST_BACKOFF: begin
          if (timeout_c) state <= ST_REQ;
        end
        ST_HOLD,
        ST_FAIL: begin
          if (sync_now || timeout_c) begin
            retry_cnt <= '0;
            state     <= ST_REQ;
          end
        end
        default: state <= ST_START;
      endcase
      if (manual_req) begin
        load_n    <= 1'b0;
        set_value <= manual_value;
        synced    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_time_sync_scheduler.sv
// Scoreboard bench for time_sync_scheduler with a 10-cycle second.
module tb_time_sync_scheduler;

  localparam logic [31:0] T_GOOD  = 32'h66DF0000;
  localparam logic [31:0] T_GOOD2 = 32'h66DF1234;
  localparam logic [31:0] T_BAD   = 32'h00001000;
  localparam logic [63:0] MAN_A   = 64'h0000000170000000;
  localparam logic [63:0] MAN_B   = 64'h0000000180000001;
  localparam logic [63:0] MAN_C   = 64'h00000001900000AB;

  typedef struct {
    logic [63:0] value;
    logic        synced;
  } load_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        manual_req;
  logic [63:0] manual_value;
  logic        sync_now;
  logic        net_en;
  logic        net_finished;
  logic [31:0] net_time;
  logic        load_n;
  logic [63:0] set_value;
  logic        synced;
  logic        fail;
  logic [2:0]  retry_cnt;

  load_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc   = 0;

  time_sync_scheduler #(
    .CLK_HZ        (10),
    .RESP_TIMEOUT_S(2),
    .BACKOFF_S     (1),
    .MAX_RETRY     (3),
    .RESYNC_S      (5)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .manual_req  (manual_req),
    .manual_value(manual_value),
    .sync_now    (sync_now),
    .net_en      (net_en),
    .net_finished(net_finished),
    .net_time    (net_time),
    .load_n      (load_n),
    .set_value   (set_value),
    .synced      (synced),
    .fail        (fail),
    .retry_cnt   (retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic wait_en(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (net_en === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("net_en_seen", 64'(net_en), 64'd1);
  endtask

  task automatic respond(input logic [31:0] t, input bit push);
    net_finished = 1'b1;
    net_time     = t;
    if (push) exp_q.push_back('{value: {32'd0, t}, synced: 1'b1});
    step();
    net_finished = 1'b0;
    net_time     = '0;
  endtask

  task automatic manual(input logic [63:0] v);
    manual_req   = 1'b1;
    manual_value = v;
    exp_q.push_back('{value: v, synced: 1'b0});
  endtask

  task automatic reset_outs(input string p);
    check({p, "_net_en"},    64'(net_en),    64'd0);
    check({p, "_load_n"},    64'(load_n),    64'd1);
    check({p, "_set_value"}, set_value,      64'd0);
    check({p, "_synced"},    64'(synced),    64'd0);
    check({p, "_fail"},      64'(fail),      64'd0);
    check({p, "_retry_cnt"}, 64'(retry_cnt), 64'd0);
  endtask

  // Every load strobe must match the oldest pending expectation
  always @(negedge clk) begin
    load_t e;
    if (load_n === 1'b0) begin
      check("load_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("load_value", set_value, e.value);
        check("load_synced", 64'(synced), 64'(e.synced));
      end
    end
  end

  initial begin
    int at, t0, x, lt, e, f0, g, s, h, m, n;
    reset_n      = 1'b0;
    manual_req   = 1'b0;
    manual_value = '0;
    sync_now     = 1'b0;
    net_finished = 1'b0;
    net_time     = '0;
    step(3);
    reset_outs("rst");

    // Release: START, then request
    reset_n = 1'b1;
    t0 = cyc;
    wait_en(10, at);
    check("rst_to_en", 64'(at - t0), 64'd2);

    // Valid response three cycles after the request
    x = at;
    step(3);
    respond(T_GOOD, 1'b1);
    step();
    check("s1_load_n_early", 64'(load_n), 64'd1);
    step();
    check("s1_load_n", 64'(load_n), 64'd0);
    check("s1_synced", 64'(synced), 64'd1);
    check("s1_retry", 64'(retry_cnt), 64'd0);
    check("s1_latency", 64'(cyc - x), 64'd6);
    lt = cyc;
    step();
    check("s1_load_n_single", 64'(load_n), 64'd1);

    // Resync after the hold period
    wait_en(60, at);
    check("s5_hold_gap", 64'(at - lt), 64'd50);
    e = at;

    // sync_now while waiting is ignored; then no response at all
    step(2);
    sync_now = 1'b1;
    step();
    sync_now = 1'b0;
    step();
    check("s5_wait_sync_ignored", 64'(net_en), 64'd0);
    wait_en(40, at);
    check("s2_gap1", 64'(at - e), 64'd30);
    check("s2_retry1", 64'(retry_cnt), 64'd1);
    e = at;
    wait_en(40, at);
    check("s2_gap2", 64'(at - e), 64'd30);
    check("s2_retry2", 64'(retry_cnt), 64'd2);
    e = at;
    step(19);
    check("s2_fail_pre", 64'(fail), 64'd0);
    step();
    check("s2_fail", 64'(fail), 64'd1);
    check("s2_retry3", 64'(retry_cnt), 64'd3);
    f0 = cyc;
    wait_en(60, at);
    check("s2_fail_gap", 64'(at - f0), 64'd50);
    check("s2_retry_clr", 64'(retry_cnt), 64'd0);
    check("s2_fail_kept", 64'(fail), 64'd1);

    // Out-of-range time counts as a failed attempt
    g = at;
    step(2);
    respond(T_BAD, 1'b0);
    step(2);
    check("s3_retry", 64'(retry_cnt), 64'd1);
    check("s3_fail_kept", 64'(fail), 64'd1);
    wait_en(20, at);
    check("s3_backoff_gap", 64'(at - g), 64'd15);
    g = at;
    step(3);
    respond(T_GOOD, 1'b1);
    step(2);
    check("s3_load_n", 64'(load_n), 64'd0);
    check("s3_fail_clr", 64'(fail), 64'd0);
    check("s3_retry_clr", 64'(retry_cnt), 64'd0);
    check("s3_synced", 64'(synced), 64'd1);
    lt = cyc;

    // sync_now ten cycles into hold
    step(10);
    sync_now = 1'b1;
    s = cyc;
    step();
    sync_now = 1'b0;
    check("s5_sync_req", 64'(net_en), 64'd0);
    step();
    check("s5_sync_en", 64'(net_en), 64'd1);
    check("s5_sync_retry", 64'(retry_cnt), 64'd0);
    check("s5_sync_lat", 64'(cyc - s), 64'd2);

    // Manual set colliding with the network load
    h = cyc;
    step(3);
    respond(T_GOOD2, 1'b0);
    step();
    manual(MAN_A);
    step();
    manual_req = 1'b0;
    check("s4_load_n", 64'(load_n), 64'd0);
    check("s4_synced", 64'(synced), 64'd0);
    check("s4_retry", 64'(retry_cnt), 64'd0);
    check("s4_latency", 64'(cyc - h), 64'd6);
    lt = cyc;
    step();
    check("s4_load_single", 64'(load_n), 64'd1);
    wait_en(60, at);
    check("s4_hold_gap", 64'(at - lt), 64'd50);

    // Back-to-back manual loads while a sync is in flight
    m = at;
    manual(MAN_B);
    step();
    manual(MAN_C);
    step();
    manual_req = 1'b0;
    check("man_b2b_load_n", 64'(load_n), 64'd0);
    check("man_b2b_synced", 64'(synced), 64'd0);
    step();
    respond(T_GOOD, 1'b1);
    step(2);
    check("man_sync_cont", 64'(load_n), 64'd0);
    check("man_sync_synced", 64'(synced), 64'd1);
    check("man_sync_lat", 64'(cyc - m), 64'd6);

    // Reset during WAIT, then a late response
    wait_en(60, at);
    n = at;
    step(2);
    reset_n = 1'b0;
    step(2);
    reset_outs("s6");
    reset_n      = 1'b1;
    net_finished = 1'b1;
    net_time     = T_GOOD;
    t0 = cyc;
    step();
    net_finished = 1'b0;
    net_time     = '0;
    check("s6_start", 64'(net_en), 64'd0);
    wait_en(10, at);
    check("s6_rst_to_en", 64'(at - t0), 64'd2);
    check("s6_from_wait", 64'(t0 - n), 64'd4);
    step(5);
    check("s6_no_load", 64'(load_n), 64'd1);
    check("sb_drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
